twiddle_loader: RTL and testbench

Writer-side counterpart to the FFT twiddle-factor ROM: accepts 16 complex twiddle coefficients over a valid/ready stream and presents them as 16 parallel real/imag Q1.15 words with the same output port set as the ROM, so the 32-point radix-2 FFT datapath can take its twiddles from either source unchanged. Coefficients are written into a shadow bank and committed atomically to the active bank, so the datapath never sees a partially reloaded set. The block sits between the host/configuration interface and the butterfly stages.

---
 rtl/twiddle_loader.sv | 167 ++++++++++++++++
 tb/tb_twiddle_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_loader.sv
// Streaming writer for the 16-entry FFT twiddle set: loads a shadow bank over
// valid/ready and commits it atomically to the active bank driving W0..W15.
module twiddle_loader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_wr,
  input  logic [WIDTH-1:0] in_wi,
  output logic             busy,
  output logic             loaded,
  output logic             done,
  output logic [WIDTH-1:0] W0r,
  output logic [WIDTH-1:0] W1r,
  output logic [WIDTH-1:0] W2r,
  output logic [WIDTH-1:0] W3r,
  output logic [WIDTH-1:0] W4r,
  output logic [WIDTH-1:0] W5r,
  output logic [WIDTH-1:0] W6r,
  output logic [WIDTH-1:0] W7r,
  output logic [WIDTH-1:0] W8r,
  output logic [WIDTH-1:0] W9r,
  output logic [WIDTH-1:0] W10r,
  output logic [WIDTH-1:0] W11r,
  output logic [WIDTH-1:0] W12r,
  output logic [WIDTH-1:0] W13r,
  output logic [WIDTH-1:0] W14r,
  output logic [WIDTH-1:0] W15r,
  output logic [WIDTH-1:0] W0i,
  output logic [WIDTH-1:0] W1i,
  output logic [WIDTH-1:0] W2i,
  output logic [WIDTH-1:0] W3i,
  output logic [WIDTH-1:0] W4i,
  output logic [WIDTH-1:0] W5i,
  output logic [WIDTH-1:0] W6i,
  output logic [WIDTH-1:0] W7i,
  output logic [WIDTH-1:0] W8i,
  output logic [WIDTH-1:0] W9i,
  output logic [WIDTH-1:0] W10i,
  output logic [WIDTH-1:0] W11i,
  output logic [WIDTH-1:0] W12i,
  output logic [WIDTH-1:0] W13i,
  output logic [WIDTH-1:0] W14i,
  output logic [WIDTH-1:0] W15i
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [IW-1:0]   idx;
  logic            load_hs;

  logic [WIDTH-1:0] sh_r  [DEPTH];
  logic [WIDTH-1:0] sh_i  [DEPTH];
  logic [WIDTH-1:0] act_r [DEPTH];
  logic [WIDTH-1:0] act_i [DEPTH];

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    load_hs    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start && !abort) next_state = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (abort) begin
          next_state = IDLE;
        end else if (in_valid) begin
          load_hs = 1'b1;
          if (idx == IW'(DEPTH - 1)) next_state = COMMIT;
        end
      end
      COMMIT: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: both banks are reset explicitly because W outputs must read zero
  // after reset; this keeps them as flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      loaded <= 1'b0;
      done   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        sh_r[k]  <= '0;
        sh_i[k]  <= '0;
        act_r[k] <= '0;
        act_i[k] <= '0;
      end
    end else begin
      done <= (state == COMMIT);
      if (state == IDLE && start && !abort) idx <= '0;
      if (load_hs) begin
        sh_r[idx] <= in_wr;
        sh_i[idx] <= in_wi;
        idx       <= idx + 1'b1;
      end
      // Whole-bank copy in one edge: the datapath never sees a mixed set.
      if (state == COMMIT) begin
        loaded <= 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
          act_r[k] <= sh_r[k];
          act_i[k] <= sh_i[k];
        end
      end
    end
  end

  assign W0r  = act_r[0];
  assign W1r  = act_r[1];
  assign W2r  = act_r[2];
  assign W3r  = act_r[3];
  assign W4r  = act_r[4];
  assign W5r  = act_r[5];
  assign W6r  = act_r[6];
  assign W7r  = act_r[7];
  assign W8r  = act_r[8];
  assign W9r  = act_r[9];
  assign W10r = act_r[10];
  assign W11r = act_r[11];
  assign W12r = act_r[12];
  assign W13r = act_r[13];
  assign W14r = act_r[14];
  assign W15r = act_r[15];
  assign W0i  = act_i[0];
  assign W1i  = act_i[1];
  assign W2i  = act_i[2];
  assign W3i  = act_i[3];
  assign W4i  = act_i[4];
  assign W5i  = act_i[5];
  assign W6i  = act_i[6];
  assign W7i  = act_i[7];
  assign W8i  = act_i[8];
  assign W9i  = act_i[9];
  assign W10i = act_i[10];
  assign W11i = act_i[11];
  assign W12i = act_i[12];
  assign W13i = act_i[13];
  assign W14i = act_i[14];
  assign W15i = act_i[15];

endmodule

// File: tb/tb_twiddle_loader.sv
// Directed bench for twiddle_loader: words queued on drive, popped and compared
// against the W outputs when done pulses; active set checked every load cycle.
module tb_twiddle_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic [15:0] in_wr;
  logic [15:0] in_wi;
  logic        in_ready;
  logic        busy;
  logic        loaded;
  logic        done;
  logic [15:0] w_r [16];
  logic [15:0] w_i [16];

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_q [$];
  logic [15:0] exp_r [16];
  logic [15:0] exp_i [16];
  logic [15:0] a_r [16], a_i [16];
  logic [15:0] b_r [16], b_i [16];
  logic [15:0] c_r [16], c_i [16];

  always #5 clk = ~clk;

  twiddle_loader #(.WIDTH(16), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr), .in_wi(in_wi),
    .busy(busy), .loaded(loaded), .done(done),
    .W0r(w_r[0]),   .W1r(w_r[1]),   .W2r(w_r[2]),   .W3r(w_r[3]),
    .W4r(w_r[4]),   .W5r(w_r[5]),   .W6r(w_r[6]),   .W7r(w_r[7]),
    .W8r(w_r[8]),   .W9r(w_r[9]),   .W10r(w_r[10]), .W11r(w_r[11]),
    .W12r(w_r[12]), .W13r(w_r[13]), .W14r(w_r[14]), .W15r(w_r[15]),
    .W0i(w_i[0]),   .W1i(w_i[1]),   .W2i(w_i[2]),   .W3i(w_i[3]),
    .W4i(w_i[4]),   .W5i(w_i[5]),   .W6i(w_i[6]),   .W7i(w_i[7]),
    .W8i(w_i[8]),   .W9i(w_i[9]),   .W10i(w_i[10]), .W11i(w_i[11]),
    .W12i(w_i[12]), .W13i(w_i[13]), .W14i(w_i[14]), .W15i(w_i[15])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit bank_matches();
    for (int k = 0; k < 16; k++)
      if (w_r[k] !== exp_r[k] || w_i[k] !== exp_i[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_bank_words(input string tag);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_W%0dr", tag, k), {16'h0, w_r[k]}, {16'h0, exp_r[k]});
      check($sformatf("%s_W%0di", tag, k), {16'h0, w_i[k]}, {16'h0, exp_i[k]});
    end
  endtask

  // Loads one set; stalls of stall_len cycles follow words 4 and 11 if nonzero.
  task automatic load_set(input string tag, input logic [15:0] r [16],
                          input logic [15:0] i [16], input int stall_len,
                          input int exp_edges);
    int edges;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    check({tag, "_done_clear"}, {31'h0, done}, 32'd0);
    check({tag, "_busy"}, {31'h0, busy}, 32'd1);
    check({tag, "_ready"}, {31'h0, in_ready}, 32'd1);
    check({tag, "_idx_start"}, {28'h0, dut.idx}, 32'd0);
    for (int n = 0; n < 16; n++) begin
      in_valid = 1'b1;
      in_wr    = r[n];
      in_wi    = i[n];
      sb_q.push_back({r[n], i[n]});
      tick();
      edges++;
      check({tag, "_atomic"}, {31'h0, bank_matches()}, 32'd1);
      if ((n == 3 || n == 10) && stall_len > 0) begin
        in_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          edges++;
          check({tag, "_idx_hold"}, {28'h0, dut.idx}, n + 1);
          check({tag, "_atomic_stall"}, {31'h0, bank_matches()}, 32'd1);
        end
      end
    end
    in_valid = 1'b0;
    check({tag, "_commit_ready"}, {31'h0, in_ready}, 32'd0);
    check({tag, "_commit_busy"}, {31'h0, busy}, 32'd1);
    for (int c = 0; c < 8 && !done; c++) begin
      tick();
      edges++;
      if (!done) check({tag, "_atomic_wait"}, {31'h0, bank_matches()}, 32'd1);
    end
    check({tag, "_done_seen"}, {31'h0, done}, 32'd1);
    check({tag, "_done_edge"}, edges, exp_edges);
    check({tag, "_loaded"}, {31'h0, loaded}, 32'd1);
    check({tag, "_idle_after"}, {31'h0, busy}, 32'd0);
    check({tag, "_sb_depth"}, sb_q.size(), 32'd16);
    for (int k = 0; k < 16; k++) begin
      if (sb_q.size() > 0) {exp_r[k], exp_i[k]} = sb_q.pop_front();
    end
    check_bank_words(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_wr = '0; in_wi = '0;
    for (int k = 0; k < 16; k++) begin
      a_r[k] = 16'h7FFF - 16'(k);
      a_i[k] = 16'h8000 + 16'(k);
      b_r[k] = 16'(k * 16'h1111) ^ 16'h0F0F;
      b_i[k] = ~(16'(k * 16'h1111) ^ 16'h0F0F);
      c_r[k] = 16'($urandom);
      c_i[k] = 16'($urandom);
      exp_r[k] = '0;
      exp_i[k] = '0;
    end

    // Reset, then idle with in_valid asserted.
    #12 rst = 1'b0;
    in_valid = 1'b1;
    repeat (5) tick();
    check("rst_ready", {31'h0, in_ready}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_loaded", {31'h0, loaded}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check_bank_words("rst");
    in_valid = 1'b0;

    // start together with abort must not leave IDLE.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", {31'h0, busy}, 32'd0);

    load_set("full_a", a_r, a_i, 0, 17);
    check("full_a_W5r", {16'h0, w_r[5]}, 32'h7FFA);
    check("full_a_W5i", {16'h0, w_i[5]}, 32'h8005);
    tick();
    check("done_one_cycle", {31'h0, done}, 32'd0);

    load_set("stall_a", a_r, a_i, 3, 23);
    tick();

    // Abort after 7 words of set B, with in_valid still high.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 7; n++) begin
      in_valid = 1'b1; in_wr = b_r[n]; in_wi = b_i[n];
      tick();
    end
    abort = 1'b1; in_valid = 1'b1; in_wr = b_r[7]; in_wi = b_i[7];
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_ready", {31'h0, in_ready}, 32'd0);
    check("abort_done", {31'h0, done}, 32'd0);
    check("abort_loaded", {31'h0, loaded}, 32'd1);
    check("abort_no_write", {28'h0, dut.idx}, 32'd7);
    check("abort_bank_a", {31'h0, bank_matches()}, 32'd1);
    repeat (2) tick();
    check("abort_no_done", {31'h0, done}, 32'd0);

    // Reload atomicity A -> B, then C started in the cycle done is high.
    load_set("reload_b", b_r, b_i, 0, 17);
    load_set("reload_c", c_r, c_i, 0, 17);
    tick();

    // Asynchronous reset between edges while word 9 is offered.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1; in_wr = a_r[n]; in_wi = a_i[n];
      tick();
    end
    in_wr = a_r[8]; in_wi = a_i[8];
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) begin
      exp_r[k] = '0;
      exp_i[k] = '0;
    end
    check("arst_ready", {31'h0, in_ready}, 32'd0);
    check("arst_busy", {31'h0, busy}, 32'd0);
    check("arst_loaded", {31'h0, loaded}, 32'd0);
    check("arst_bank_zero", {31'h0, bank_matches()}, 32'd1);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    tick();
    load_set("after_rst_a", a_r, a_i, 0, 17);
    check("after_rst_W5r", {16'h0, w_r[5]}, 32'h7FFA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
